// File: rtl/uart_word_tx.sv
// uart_word_tx
// Serialises one parallel word as NUM_BYTES back-to-back 8N1 frames,
// least-significant byte first. The bit period is chosen per word from
// sel_baud (0:4800, 1:9600, 2:19200, 3:38400 baud) and latched with the word.
//
// Ports:
//   sys_clk    system clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   sel_baud   baud select, sampled when a start is accepted
//   tx_start   send request (pulse or level); ignored while busy
//   tx_word    word to send, sampled when a start is accepted
//   tx_data    serial line, idle high, driven from a register
//   tx_status  busy flag
//   tx_done    one-cycle pulse as the last stop bit of the word completes
module uart_word_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int NUM_BYTES = 4,
  localparam int DATA_W   = 8 * NUM_BYTES
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [1:0]        sel_baud,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_word,
  output logic              tx_data,
  output logic              tx_status,
  output logic              tx_done
);

  // Slowest baud gives the largest divisor; the counter holds DIV-1.
  localparam int DIV_MAX = CLK_FREQ / 4800;
  localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bit period minus one for a baud select code (truncating division).
  function automatic logic [CNT_W-1:0] div_m1(input logic [1:0] sel);
    logic [CNT_W-1:0] r;
    case (sel)
      2'd0:    r = CNT_W'(CLK_FREQ / 4800 - 1);
      2'd1:    r = CNT_W'(CLK_FREQ / 9600 - 1);
      2'd2:    r = CNT_W'(CLK_FREQ / 19200 - 1);
      2'd3:    r = CNT_W'(CLK_FREQ / 38400 - 1);
      default: r = CNT_W'(CLK_FREQ / 4800 - 1);
    endcase
    return r;
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [CNT_W-1:0]    div_r, div_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic [2:0]          bit_idx_r, bit_idx_s;
  logic [BYTE_W-1:0]   byte_idx_r, byte_idx_s;
  logic                tx_data_r, status_r, done_r;
  logic                line_s, last_end_s, bit_end_s;

  // Next-state, counter and shift-register update; line level for current state.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    div_s      = div_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    line_s     = 1'b1;
    last_end_s = 1'b0;
    bit_end_s  = (cnt_r == {CNT_W{1'b0}});
    case (state_r)
      IDLE: begin
        line_s = 1'b1;
        if (tx_start) begin
          state_s    = START;
          cnt_s      = div_m1(sel_baud);
          div_s      = div_m1(sel_baud);
          shift_s    = tx_word;
          bit_idx_s  = 3'd0;
          byte_idx_s = {BYTE_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        line_s = 1'b0;
        if (bit_end_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
          cnt_s     = div_r;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      DATA: begin
        // The current byte always sits in the low bits of the shift register.
        line_s = shift_r[0];
        if (bit_end_s) begin
          cnt_s   = div_r;
          shift_s = {1'b0, shift_r[DATA_W-1:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      STOP: begin
        line_s = 1'b1;
        if (!bit_end_s) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (byte_idx_r != LAST_BYTE) begin
          byte_idx_s = byte_idx_r + BYTE_W'(1);
          state_s    = START;
          cnt_s      = div_r;
        end else begin
          // Word ends here. The line register lags the state by one cycle, so a
          // start accepted now puts the next start bit right after this stop bit.
          last_end_s = 1'b1;
          if (tx_start) begin
            state_s    = START;
            cnt_s      = div_m1(sel_baud);
            div_s      = div_m1(sel_baud);
            shift_s    = tx_word;
            bit_idx_s  = 3'd0;
            byte_idx_s = {BYTE_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
      end
      default: begin
        state_s = IDLE;
        line_s  = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs, with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      div_r      <= {CNT_W{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
      bit_idx_r  <= 3'd0;
      byte_idx_r <= {BYTE_W{1'b0}};
      tx_data_r  <= 1'b1;
      status_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_r      <= div_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      tx_data_r  <= line_s;
      status_r   <= (state_r != IDLE) && !last_end_s;
      done_r     <= last_end_s;
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_status = status_r;
  assign tx_done   = done_r;

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Multi-byte UART transmitter: takes one parallel result word and sends it as NUM_BYTES consecutive 8N1 frames, least-significant byte first.
- Sits on the result path of the UART converter: it serialises the 32-bit conversion/ALU result back to the host.
- Baud rate is runtime-selectable with the same sel_baud encoding as the receive side.

Parameters:
CLK_FREQ, 100_000_000, sys_clk frequency in Hz; used to derive the bit-period divisors
NUM_BYTES, 4, bytes per word (must be >= 1)
DATA_W, 8*NUM_BYTES, word width; derived, not overridden

Ports:
sys_clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-low reset; 0 = reset, sampled on the sys_clk rising edge
sel_baud  input  2  0:4800, 1:9600, 2:19200, 3:38400
tx_start  input  1  request to send tx_word; single-cycle or level
tx_word  input  DATA_W  word to transmit; sampled only when a start is accepted
tx_data  output  1  serial line out, idle high
tx_status  output  1  busy: 1 from the cycle after acceptance until the word completes
tx_done  output  1  one-cycle pulse when the last stop bit finishes

Behaviour:
- Reset (rst=0 at a clock edge):
  - tx_data=1, tx_status=0, tx_done=0.
  - FSM goes to IDLE; all counters and the shift register clear.
  - Reset mid-frame aborts the frame: the line is high on the cycle after the reset edge, and no tx_done is produced.
- Divisor: DIV = CLK_FREQ/baud, integer truncation, computed per sel_baud.
  - sel_baud is latched together with tx_word at acceptance.
  - Changes to sel_baud during a word have no effect until the next word.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_data=1. When tx_start=1 at an edge, latch tx_word and sel_baud, set byte_idx=0, go to START. tx_status=1 from the next cycle.
  - START: tx_data=0 for DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx_data = byte[byte_idx] bit[bit_idx], LSB first, each bit held DIV cycles. After bit 7 go to STOP.
  - STOP: tx_data=1 for DIV cycles.
    - If byte_idx < NUM_BYTES-1: byte_idx++, go to START immediately, with no extra idle gap.
    - Otherwise go to IDLE.
- Byte order: byte k = tx_word[8k+7:8k]; byte 0 is sent first.
- Timing:
  - Start accepted at edge N: the first start bit is driven from edge N+1.
  - Each frame is 10*DIV cycles; the whole word is NUM_BYTES*10*DIV cycles.
  - On the edge ending the last stop bit: FSM enters IDLE, tx_done=1 for exactly that cycle, tx_status=0 in the same cycle.
- Back-to-back words:
  - tx_start high during the tx_done cycle is accepted.
  - The next start bit follows immediately, with zero idle cycles.
- tx_start while tx_status=1 is ignored; it is not queued. tx_word changes while busy do not affect the frame in flight.
- Bit-period counter counts DIV-1 down to 0. No fractional correction; the divisor error from truncation is accepted.
- tx_data is driven from a register (glitch-free, no combinational path from inputs).

Test Plan:
All scenarios use CLK_FREQ=384000, giving DIV = 80/40/20/10 for sel_baud 0/1/2/3.

1. Reset: hold rst=0 for 3 cycles with tx_start=1 -> tx_data=1, tx_status=0, tx_done=0 throughout. After release with tx_start=0, line stays high.
2. Basic word: sel_baud=3, tx_word=0xDEADBEEF, pulse tx_start at edge N.
   - Line carries bytes EF, BE, AD, DE.
   - First byte bits after the start bit are 1,1,1,1,0,1,1,1; each bit is 10 cycles.
   - tx_done pulses exactly at N+400; tx_status is high from N+1 to N+399.
3. Baud select: sel_baud=0, tx_word=0x00000055 -> start-bit low lasts 80 cycles, total 3200 cycles. Changing sel_baud to 3 mid-word does not alter bit length.
4. Busy/back-to-back:
   - Second tx_start at N+100 (word 0x12345678) is ignored; the line still sends 0xDEADBEEF.
   - tx_start held high through the tx_done cycle -> next start bit begins at N+401 with no idle gap.
5. Reset mid-frame: rst=0 at N+150 -> tx_data=1 and tx_status=0 from the following cycle, no tx_done. A new word sent after release is bit-exact.
6. NUM_BYTES=1, sel_baud=2, tx_word=0xA5 -> a single frame 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 20 cycles; tx_done at N+200.
